bextdep_issue: RTL and testbench



---
 rtl/bextdep_pkg.sv | 20 ++
 rtl/bextdep_req_fifo.sv | 54 +++++
 rtl/bextdep_issue.sv | 142 ++++++++++++++
 tb/tb_bextdep_issue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bextdep_pkg.sv
// Shared types and constants for the bext/bdep issue stage.
package bextdep_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_MAX_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Request payload; tag is stored at its widest and narrowed by the top.
  typedef struct packed {
    logic                 bdep;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [TAG_MAX_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/bextdep_req_fifo.sv
// Request FIFO for the bext/bdep issue stage; DEPTH must be a power of two.
module bextdep_req_fifo
  import bextdep_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bextdep_issue.sv
// Issue stage in front of the iterative bext/bdep unit: buffers requests, launches one at a time.
// Optional BEXTDEP_ZERO_MASK_BYPASS_EN retires rs2==0 requests without using the unit.
module bextdep_issue
  import bextdep_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bdep,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             core_reset,
  output logic             core_start,
  output logic             core_bdep,
  output logic [XLEN-1:0]  core_rs1,
  output logic [XLEN-1:0]  core_rs2,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic [XLEN-1:0]  core_rd
);

`ifdef BEXTDEP_ZERO_MASK_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  req_t push_req;
  req_t head;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic unused_head_tag;

  state_t           state, state_nxt;
  logic             out_valid_nxt, start_nxt, bdep_nxt;
  logic [XLEN-1:0]  out_rd_nxt, rs1_nxt, rs2_nxt;
  logic [TAG_W-1:0] out_tag_nxt, tag_q, tag_nxt;

  assign in_ready        = !fifo_full;
  assign fifo_push       = in_valid && in_ready;
  assign push_req        = '{bdep: in_bdep, rs1: in_rs1, rs2: in_rs2, tag: TAG_MAX_W'(in_tag)};
  assign unused_head_tag = ^head.tag;

  bextdep_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (fifo_push),
    .wdata (push_req),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Unit reset: held while resetn is low, dropped at the first edge after release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) core_reset <= 1'b1;
    else         core_reset <= 1'b0;
  end

  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    start_nxt     = 1'b0;
    bdep_nxt      = core_bdep;
    rs1_nxt       = core_rs1;
    rs2_nxt       = core_rs2;
    tag_nxt       = tag_q;
    out_valid_nxt = out_valid && !out_ready;
    out_rd_nxt    = out_rd;
    out_tag_nxt   = out_tag;
    case (state)
      ST_IDLE: begin
        // Launch only into an empty result slot so at most one result is outstanding.
        if (!fifo_empty && !out_valid && !core_reset) begin
          fifo_pop = 1'b1;
          if (ZERO_BYPASS && (head.rs2 == '0)) begin
            out_valid_nxt = 1'b1;
            out_rd_nxt    = '0;
            out_tag_nxt   = TAG_W'(head.tag);
          end else begin
            start_nxt = 1'b1;
            bdep_nxt  = head.bdep;
            rs1_nxt   = head.rs1;
            rs2_nxt   = head.rs2;
            tag_nxt   = TAG_W'(head.tag);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          out_valid_nxt = 1'b1;
          out_rd_nxt    = core_rd;
          out_tag_nxt   = tag_q;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_tag    <= '0;
      core_start <= 1'b0;
      core_bdep  <= 1'b0;
      core_rs1   <= '0;
      core_rs2   <= '0;
      tag_q      <= '0;
    end else begin
      state      <= state_nxt;
      out_valid  <= out_valid_nxt;
      out_rd     <= out_rd_nxt;
      out_tag    <= out_tag_nxt;
      core_start <= start_nxt;
      core_bdep  <= bdep_nxt;
      core_rs1   <= rs1_nxt;
      core_rs2   <= rs2_nxt;
      tag_q      <= tag_nxt;
    end
  end

  // The unit must report busy for every waiting cycle before it signals done.
  a_busy_before_done: assert property (@(posedge clock) disable iff (!resetn || core_reset)
    (state == ST_WAIT && !core_start && !core_done) |-> core_busy);

endmodule

// File: tb/tb_bextdep_issue.sv
// Bench for bextdep_issue with a behavioural model of the iterative bext/bdep unit.
module tb_bextdep_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clock, resetn;
  logic             in_valid, in_ready, in_bdep;
  logic [31:0]      in_rs1, in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_rd;
  logic [TAG_W-1:0] out_tag;
  logic             core_reset, core_start, core_bdep;
  logic [31:0]      core_rs1, core_rs2;
  logic             core_busy, core_done;
  logic [31:0]      core_rd;

  logic ready_fixed, ready_rand_bit, rand_ready;
  assign out_ready = rand_ready ? ready_rand_bit : ready_fixed;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  typedef struct packed { logic [31:0] rd; logic [TAG_W-1:0] tag; } exp_t;
  exp_t exp_q[$];

  bextdep_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_bdep(in_bdep),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag),
    .core_reset(core_reset), .core_start(core_start), .core_bdep(core_bdep),
    .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_busy(core_busy), .core_done(core_done), .core_rd(core_rd)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] ref_op(input logic bdep, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
    logic [31:0] r;
    int j;
    r = '0;
    j = 0;
    for (int i = 0; i < 32; i++) begin
      if (rs2[i]) begin
        if (bdep) r[i] = rs1[j];
        else      r[j] = rs1[i];
        j++;
      end
    end
    return r;
  endfunction

  function automatic int popc(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Unit model: done arrives max(1,popcount(rs2)) edges after the start pulse is seen.
  int m_rem;
  logic [31:0] m_res;
  always @(posedge clock) begin
    if (core_reset) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_rd   <= '0;
      m_rem     <= 0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        if (popc(core_rs2) <= 1) begin
          core_done <= 1'b1;
          core_rd   <= ref_op(core_bdep, core_rs1, core_rs2);
        end else begin
          core_busy <= 1'b1;
          m_rem     <= popc(core_rs2) - 1;
          m_res     <= ref_op(core_bdep, core_rs1, core_rs2);
        end
      end else if (core_busy) begin
        if (m_rem == 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
          core_rd   <= m_res;
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    ready_rand_bit = 1'($urandom_range(0, 1));
  end

  always @(negedge clock) if (core_start) start_cnt++;

  // Scoreboard: each consumed result must be the oldest outstanding request.
  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL out_unexpected observed rd=0x%0h tag=%0d expected no result", out_rd, out_tag);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_rd", out_rd, e.rd);
        check("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  task automatic push(input logic bdep, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_bdep  = bdep;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_tag   = tag;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clock);
      ok = in_ready;
    end
    if (ok) begin
      @(posedge clock);
      exp_q.push_back('{rd: ref_op(bdep, rs1, rs2), tag: tag});
      #1;
    end else begin
      check("push_timeout", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge to the first cycle with out_valid high.
  task automatic measure(input string name, input bit exp_start, input int exp_lat,
                         input logic [31:0] exp_rs1, input logic [31:0] exp_rs2);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 80 && !seen; k++) begin
      @(posedge clock);
      @(negedge clock);
      n = k;
      if (k == 1) check({name, "_start"}, 32'(core_start), 32'(exp_start));
      if (k == 1 && exp_start) check({name, "_rs2"}, core_rs2, exp_rs2);
      if (k == 2) check({name, "_start_pulse"}, 32'(core_start), 32'd0);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (exp_start) check({name, "_rs1_held"}, core_rs1, exp_rs1);
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    bit done_f;
    done_f = 1'b0;
    for (int k = 0; k < 5000 && !done_f; k++) begin
      @(negedge clock);
      done_f = (exp_q.size() == 0) && !out_valid;
    end
    check(name, 32'(done_f), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [31:0] r1, r2;
    resetn = 1'b0; in_valid = 1'b0; in_bdep = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    ready_fixed = 1'b1; rand_ready = 1'b0;

    // Reset state and core_reset release timing
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rd", out_rd, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1; resetn = 1'b1;
    @(negedge clock);
    check("rel_core_reset_hold", 32'(core_reset), 32'd1);
    @(negedge clock);
    check("rel_core_reset_clear", 32'(core_reset), 32'd0);
    check("rel_no_start", 32'(start_cnt), 32'd0);
    @(posedge clock); #1;

    // Single bext and bdep with latency
    push(1'b0, 32'h12345678, 32'h0000FF00, 4'd3);
    measure("bext", 1'b1, 10, 32'h12345678, 32'h0000FF00);
    push(1'b1, 32'h000000FF, 32'h0F0F0000, 4'd5);
    measure("bdep", 1'b1, 10, 32'h000000FF, 32'h0F0F0000);

    // Zero mask
    s0 = start_cnt;
`ifdef BEXTDEP_ZERO_MASK_BYPASS_EN
    push(1'b0, 32'hDEADBEEF, 32'h0, 4'd7);
    measure("zmask", 1'b0, 1, 32'h0, 32'h0);
    check("zmask_no_start", 32'(start_cnt - s0), 32'd0);
`else
    push(1'b0, 32'hDEADBEEF, 32'h0, 4'd7);
    measure("zmask", 1'b1, 3, 32'hDEADBEEF, 32'h0);
    check("zmask_one_start", 32'(start_cnt - s0), 32'd1);
`endif
    drain("drain_directed");

    // Back-pressure: one result held, FIFO fills
    ready_fixed = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(1'($urandom_range(0, 1)), $urandom, $urandom, 4'(8 + i));
    repeat (40) @(negedge clock);
    s0 = start_cnt;
    repeat (10) @(negedge clock);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head_tag", 32'(out_tag), 32'd8);
    check("bp_no_launch", 32'(start_cnt - s0), 32'd0);
    @(posedge clock); #1;
    ready_fixed = 1'b1;
    push(1'b0, $urandom, $urandom, 4'(8 + DEPTH + 1));
    drain("drain_backpressure");

    // Reset in the middle of an operation
    push(1'b0, 32'hCAFEF00D, 32'hFFFFFFFF, 4'd2);
    repeat (6) begin @(posedge clock); #1; end
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_core_reset", 32'(core_reset), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    s0 = start_cnt;
    repeat (2) @(posedge clock);
    #1; resetn = 1'b1;
    @(negedge clock);
    check("mid_core_reset_hold", 32'(core_reset), 32'd1);
    @(negedge clock);
    check("mid_core_reset_clear", 32'(core_reset), 32'd0);
    repeat (40) @(negedge clock);
    check("mid_nothing_emitted", 32'(out_valid), 32'd0);
    check("mid_no_launch", 32'(start_cnt - s0), 32'd0);
    @(posedge clock); #1;
    push(1'b1, 32'h0000000F, 32'h80808080, 4'd9);
    measure("post_reset", 1'b1, 6, 32'h0000000F, 32'h80808080);
    drain("drain_post_reset");

    // Randomised traffic with random output back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r1 = $urandom;
      case ($urandom_range(0, 3))
        0:       r2 = 32'h0;
        1:       r2 = $urandom;
        2:       r2 = $urandom & $urandom & $urandom;
        default: r2 = 32'h1 << $urandom_range(0, 31);
      endcase
      push(1'($urandom_range(0, 1)), r1, r2, 4'(i));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    drain("drain_random");
    rand_ready = 1'b0;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
